// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, an output register
// for the decode stage, and a one-entry skid buffer that absorbs a response arriving under stall.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic [4:0]  fetch_rs1_o,
    output logic [4:0]  fetch_rs2_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    state_t      state, state_nxt;
    logic [31:0] next_pc;
    logic [31:0] req_addr;

    logic        vld_p1;
    logic [31:0] instr_p1;
    logic [31:0] pc_p1;

    logic        skid_vld;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic        advance;
    logic        issue;
    logic        redirect;
    logic        out_from_mem;
    logic        out_from_skid;
    logic        out_clear;
    logic        skid_fill;
    logic        skid_clear;

    // stall only matters when the output register holds something
    assign advance = vld_p1 && !stall_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        issue         = 1'b0;
        redirect      = 1'b0;
        out_from_mem  = 1'b0;
        out_from_skid = 1'b0;
        out_clear     = 1'b0;
        skid_fill     = 1'b0;
        skid_clear    = 1'b0;
        if (flush_i) begin
            redirect   = 1'b1;
            out_clear  = 1'b1;
            skid_clear = 1'b1;
            if (state == S_WAIT) begin
                state_nxt = imem_ack_i ? S_IDLE : S_DROP;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (!skid_vld) begin
                        issue     = 1'b1;
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack_i) begin
                        if (!vld_p1 || advance) begin
                            out_from_mem = 1'b1;
                            issue        = 1'b1;
                        end else begin
                            skid_fill = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_ack_i) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
            // a consumed output is refilled from the skid entry, or emptied
            if (advance && !out_from_mem) begin
                if (skid_vld) begin
                    out_from_skid = 1'b1;
                    skid_clear    = 1'b1;
                end else begin
                    out_clear = 1'b1;
                end
            end
        end
    end

    // ---- request address / next-fetch PC ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_pc  <= word_align(RESET_PC);
            req_addr <= word_align(RESET_PC);
        end else if (redirect) begin
            next_pc <= word_align(redirect_pc_i);
        end else if (issue) begin
            req_addr <= next_pc;
            next_pc  <= next_pc + 32'd4;
        end
    end

    // ---- output register (p1) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            instr_p1 <= '0;
            pc_p1    <= '0;
        end else if (out_clear) begin
            vld_p1 <= 1'b0;
        end else if (out_from_mem) begin
            vld_p1   <= 1'b1;
            instr_p1 <= imem_rdata_i;
            pc_p1    <= req_addr;
        end else if (out_from_skid) begin
            vld_p1   <= 1'b1;
            instr_p1 <= skid_instr;
            pc_p1    <= skid_pc;
        end
    end

    // ---- skid buffer ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_vld   <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (skid_clear) begin
            skid_vld <= 1'b0;
        end else if (skid_fill) begin
            skid_vld   <= 1'b1;
            skid_instr <= imem_rdata_i;
            skid_pc    <= req_addr;
        end
    end

    assign imem_req_o    = (state != S_IDLE);
    assign imem_addr_o   = req_addr;
    assign fetch_valid_o = vld_p1;
    assign fetch_instr_o = instr_p1;
    assign fetch_pc_o    = pc_p1;
    assign fetch_rs1_o   = instr_p1[19:15];
    assign fetch_rs2_o   = instr_p1[24:20];

endmodule
